xadac_ex_issue: RTL and testbench

XADAC_EX_ISSUE -- requirements
Module: xadac_ex_issue

---
 rtl/xadac_pkg.sv | 22 ++
 rtl/xadac_ex_if.sv | 26 ++
 rtl/xadac_id_fifo.sv | 42 ++++
 rtl/xadac_ex_issue.sv | 118 +++++++++++
 tb/tb_xadac_ex_issue.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xadac_pkg.sv
// Shared types for the XADAC execute-issue path: request/response payloads and id width.
package xadac_pkg;

    localparam int IdWidth  = 4;
    localparam int SumWidth = 32;
    localparam int RdWidth  = 5;

    typedef logic [SumWidth-1:0] SumT;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        SumT                rs1;
        SumT                imm;
    } ExReqT;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [RdWidth-1:0] rd;
        SumT                vd;
    } ExRespT;

endpackage

// File: rtl/xadac_ex_if.sv
// Request/response link between the issue unit (Master) and the execute unit (Slave).
interface xadac_ex_if;
    import xadac_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [IdWidth-1:0] req_id;
    SumT                req_rs1;
    SumT                req_imm;
    logic               resp_valid;
    logic               resp_ready;
    logic [IdWidth-1:0] resp_id;
    logic [RdWidth-1:0] resp_rd;
    SumT                resp_vd;

    modport Master (
        output req_valid, req_id, req_rs1, req_imm, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_rd, resp_vd
    );

    modport Slave (
        input  req_valid, req_id, req_rs1, req_imm, resp_ready,
        output req_ready, resp_valid, resp_id, resp_rd, resp_vd
    );

endinterface

// File: rtl/xadac_id_fifo.sv
// In-flight id FIFO: circular buffer with push/pop/head/count; caller never pops when empty.
module xadac_id_fifo #(
    parameter int Depth = 4,
    parameter int Width = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic [Width-1:0]           din,
    input  logic                       pop,
    output logic [Width-1:0]           head,
    output logic [$clog2(Depth+1)-1:0] count
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    logic [Width-1:0]           r_mem [Depth];
    logic [PtrW-1:0]            r_wr_ptr;
    logic [PtrW-1:0]            r_rd_ptr;
    logic [$clog2(Depth+1)-1:0] r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + 1'b1;
            if (push && !pop)      r_count <= r_count + 1'b1;
            else if (pop && !push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) r_mem[r_wr_ptr] <= din;
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/xadac_ex_issue.sv
// Issue unit: one-deep request register, in-flight id tracking, one-deep writeback register.
// Define XADAC_EX_ISSUE_IDCHK_EN to check response ids against the in-flight FIFO head.
module xadac_ex_issue
    import xadac_pkg::*;
#(
    parameter int MaxOutstanding = 4,
    parameter int IdFifoDepth    = MaxOutstanding
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  ExReqT             cmd_req,
    xadac_ex_if.Master        mst,
    output logic              wb_valid,
    input  logic              wb_ready,
    output ExRespT            wb_resp,
    output logic              err_o,
    output logic              busy_o
);
    localparam int CntW     = $clog2(MaxOutstanding + 1);
    localparam int FifoCntW = $clog2(IdFifoDepth + 1);
    localparam logic [CntW:0] MaxOcc = (CntW + 1)'(MaxOutstanding);

    if (IdFifoDepth < MaxOutstanding) begin : g_bad_depth
        $error("IdFifoDepth must be >= MaxOutstanding");
    end

    logic                r_req_valid;
    ExReqT               r_req;
    logic                r_wb_valid;
    ExRespT              r_wb;
    logic [CntW-1:0]     r_inflight_cnt;
    logic [CntW:0]       w_occupancy;
    logic                w_cmd_hs;
    logic                w_req_hs;
    logic                w_resp_ready;
    logic                w_resp_hs;
    logic                w_pop;
    logic                w_fifo_empty;
    logic [IdWidth-1:0]  w_head;
    logic [FifoCntW-1:0] w_fifo_cnt;

    // A request sitting in the register counts against the limit before it is pushed.
    assign w_occupancy  = {1'b0, r_inflight_cnt} + {{CntW{1'b0}}, r_req_valid};
    assign cmd_ready    = (!r_req_valid || mst.req_ready) && (w_occupancy < MaxOcc);
    assign w_cmd_hs     = cmd_valid && cmd_ready;
    assign w_req_hs     = r_req_valid && mst.req_ready;
    assign w_resp_ready = !r_wb_valid || wb_ready;
    assign w_resp_hs    = mst.resp_valid && w_resp_ready;
    assign w_fifo_empty = (w_fifo_cnt == '0);
    // Unsolicited responses are forwarded but leave tracking untouched.
    assign w_pop        = w_resp_hs && !w_fifo_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_req_valid    <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_inflight_cnt <= '0;
        end else begin
            if (w_cmd_hs)      r_req_valid <= 1'b1;
            else if (w_req_hs) r_req_valid <= 1'b0;

            if (w_resp_hs)     r_wb_valid <= 1'b1;
            else if (wb_ready) r_wb_valid <= 1'b0;

            if (w_req_hs && !w_pop)      r_inflight_cnt <= r_inflight_cnt + 1'b1;
            else if (w_pop && !w_req_hs) r_inflight_cnt <= r_inflight_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_cmd_hs)  r_req <= cmd_req;
        if (w_resp_hs) r_wb  <= '{id: mst.resp_id, rd: mst.resp_rd, vd: mst.resp_vd};
    end

    xadac_id_fifo #(
        .Depth (IdFifoDepth),
        .Width (IdWidth)
    ) u_id_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (w_req_hs),
        .din   (r_req.id),
        .pop   (w_pop),
        .head  (w_head),
        .count (w_fifo_cnt)
    );

`ifdef XADAC_EX_ISSUE_IDCHK_EN
    logic r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_resp_hs && (w_fifo_empty || (mst.resp_id != w_head))) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    logic w_unused_head;
    assign w_unused_head = ^w_head;
    assign err_o         = 1'b0;
`endif

    assign mst.req_valid  = r_req_valid;
    assign mst.req_id     = r_req.id;
    assign mst.req_rs1    = r_req.rs1;
    assign mst.req_imm    = r_req.imm;
    assign mst.resp_ready = w_resp_ready;

    assign wb_valid = r_wb_valid;
    assign wb_resp  = r_wb;
    assign busy_o   = r_req_valid || (r_inflight_cnt != '0) || r_wb_valid;

endmodule

// File: tb/tb_xadac_ex_issue.sv
// Directed + random bench for xadac_ex_issue against a queue-based transaction model.
module tb_xadac_ex_issue;
    import xadac_pkg::*;

    localparam int MAXO = 4;

    logic   clk_i     = 1'b0;
    logic   rst_i     = 1'b1;
    logic   cmd_valid = 1'b0;
    logic   cmd_ready;
    ExReqT  cmd_req   = '0;
    logic   wb_valid;
    logic   wb_ready  = 1'b1;
    ExRespT wb_resp;
    logic   err_o;
    logic   busy_o;

    xadac_ex_if mst_if ();

    xadac_ex_issue #(.MaxOutstanding(MAXO)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_req   (cmd_req),
        .mst       (mst_if),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_resp   (wb_resp),
        .err_o     (err_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Model: request register, ids in flight, writeback register, sticky error.
    ExReqT              m_req_q[$];
    logic [IdWidth-1:0] m_ids[$];
    ExRespT             m_wb_q[$];
    logic               m_err = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req_q.delete();
        m_ids.delete();
        m_wb_q.delete();
        m_err = 1'b0;
    endtask

    task automatic set_cmd(input logic v, input logic [IdWidth-1:0] id, input logic [31:0] rs1, input logic [31:0] imm);
        cmd_valid   = v;
        cmd_req.id  = id;
        cmd_req.rs1 = rs1;
        cmd_req.imm = imm;
    endtask

    task automatic set_resp(input logic v, input logic [IdWidth-1:0] id);
        mst_if.resp_valid = v;
        mst_if.resp_id    = id;
        mst_if.resp_rd    = RdWidth'($urandom);
        mst_if.resp_vd    = $urandom;
    endtask

    // Check all outputs mid-cycle, then advance the model across the next rising edge.
    task automatic cycle();
        logic   e_req_valid, e_cmd_ready, e_resp_ready, e_wb_valid;
        logic   cmd_hs, req_hs, resp_hs, wb_hs;
        ExRespT ent;
        @(negedge clk_i);
        #1;
        e_req_valid  = (m_req_q.size() != 0);
        e_wb_valid   = (m_wb_q.size() != 0);
        e_cmd_ready  = (!e_req_valid || mst_if.req_ready) && ((m_ids.size() + m_req_q.size()) < MAXO);
        e_resp_ready = !e_wb_valid || wb_ready;
        chk("cmd_ready", cmd_ready, e_cmd_ready);
        chk("req_valid", mst_if.req_valid, e_req_valid);
        if (e_req_valid) begin
            chk("req_id", mst_if.req_id, m_req_q[0].id);
            chk("req_rs1", mst_if.req_rs1, m_req_q[0].rs1);
            chk("req_imm", mst_if.req_imm, m_req_q[0].imm);
        end
        chk("resp_ready", mst_if.resp_ready, e_resp_ready);
        chk("wb_valid", wb_valid, e_wb_valid);
        if (e_wb_valid) chk("wb_resp", wb_resp, m_wb_q[0]);
        chk("err_o", err_o, m_err);
        chk("busy_o", busy_o, e_req_valid || (m_ids.size() != 0) || e_wb_valid);

        cmd_hs  = cmd_valid && e_cmd_ready;
        req_hs  = e_req_valid && mst_if.req_ready;
        resp_hs = mst_if.resp_valid && e_resp_ready;
        wb_hs   = e_wb_valid && wb_ready;
        ent.id  = mst_if.resp_id;
        ent.rd  = mst_if.resp_rd;
        ent.vd  = mst_if.resp_vd;
`ifdef XADAC_EX_ISSUE_IDCHK_EN
        if (resp_hs && ((m_ids.size() == 0) || (mst_if.resp_id !== m_ids[0]))) m_err = 1'b1;
`endif
        if (resp_hs && (m_ids.size() != 0)) void'(m_ids.pop_front());
        if (req_hs) begin
            m_ids.push_back(m_req_q[0].id);
            void'(m_req_q.pop_front());
        end
        if (cmd_hs) m_req_q.push_back(cmd_req);
        if (wb_hs) void'(m_wb_q.pop_front());
        if (resp_hs) m_wb_q.push_back(ent);
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        model_reset();
        #1;
        chk("rst_req_valid", mst_if.req_valid, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Answer in order and accept writebacks until the model is idle (bounded).
    task automatic drain();
        set_cmd(1'b0, '0, '0, '0);
        mst_if.req_ready = 1'b1;
        wb_ready         = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (m_ids.size() != 0) set_resp(1'b1, m_ids[0]);
            else                   set_resp(1'b0, '0);
            cycle();
        end
        set_resp(1'b0, '0);
        cycle();
        chk("drain_idle", busy_o, 1'b0);
    endtask

    initial begin
        mst_if.req_ready  = 1'b1;
        mst_if.resp_valid = 1'b0;
        mst_if.resp_id    = '0;
        mst_if.resp_rd    = '0;
        mst_if.resp_vd    = '0;
        do_reset();

        // Single op: req in cycle 1, response in cycle 2, writeback in cycle 3.
        set_cmd(1'b1, 4'd3, 32'h10, 32'h2);
        cycle();
        set_cmd(1'b0, '0, '0, '0);
        chk("single_req_valid", mst_if.req_valid, 1'b1);
        chk("single_req_id", mst_if.req_id, 4'd3);
        cycle();
        set_resp(1'b1, 4'd3);
        cycle();
        set_resp(1'b0, '0);
        chk("single_wb_valid", wb_valid, 1'b1);
        chk("single_wb_id", wb_resp.id, 4'd3);
        chk("single_err", err_o, 1'b0);
        cycle();
        cycle();

        // Backpressure: request held for 5 cycles while a second cmd waits.
        mst_if.req_ready = 1'b0;
        set_cmd(1'b1, 4'd5, 32'hAAAA_0001, 32'h11);
        cycle();
        set_cmd(1'b1, 4'd6, 32'hBBBB_0002, 32'h22);
        for (int k = 0; k < 5; k++) cycle();
        chk("bp_req_id_stable", mst_if.req_id, 4'd5);
        chk("bp_cmd_ready", cmd_ready, 1'b0);
        mst_if.req_ready = 1'b1;
        cycle();
        set_cmd(1'b0, '0, '0, '0);
        cycle();
        drain();

        // Limit: four issued, no responses.
        for (int k = 0; k < 7; k++) begin
            set_cmd(1'b1, IdWidth'(k + 8), $urandom, $urandom);
            cycle();
        end
        chk("limit_cmd_ready", cmd_ready, 1'b0);
        set_resp(1'b1, m_ids[0]);
        cycle();
        set_resp(1'b0, '0);
        chk("limit_reopen", cmd_ready, 1'b1);
        cycle();
        set_cmd(1'b0, '0, '0, '0);
        set_resp(1'b1, m_ids[0]);
        cycle();
        set_resp(1'b0, '0);
        cycle();
        cycle();
        drain();

        // Out-of-order response ids.
        do_reset();
        set_cmd(1'b1, 4'd1, 32'h1, 32'h1);
        cycle();
        set_cmd(1'b1, 4'd2, 32'h2, 32'h2);
        cycle();
        set_cmd(1'b0, '0, '0, '0);
        cycle();
        set_resp(1'b1, 4'd2);
        cycle();
        set_resp(1'b1, 4'd1);
        cycle();
        set_resp(1'b0, '0);
        for (int k = 0; k < 4; k++) cycle();
`ifdef XADAC_EX_ISSUE_IDCHK_EN
        chk("mismatch_sticky", err_o, 1'b1);
`else
        chk("mismatch_tied", err_o, 1'b0);
`endif
        do_reset();

        // Writeback stall with two responses pending.
        set_cmd(1'b1, 4'd7, 32'h7, 32'h7);
        cycle();
        set_cmd(1'b1, 4'd9, 32'h9, 32'h9);
        cycle();
        set_cmd(1'b0, '0, '0, '0);
        cycle();
        wb_ready = 1'b0;
        set_resp(1'b1, 4'd7);
        cycle();
        set_resp(1'b1, 4'd9);
        chk("stall_resp_ready", mst_if.resp_ready, 1'b0);
        cycle();
        cycle();
        wb_ready = 1'b1;
        cycle();
        set_resp(1'b0, '0);
        chk("stall_second_id", wb_resp.id, 4'd9);
        cycle();
        cycle();

        // Async reset mid-flight, then an unsolicited response after release.
        set_cmd(1'b1, 4'd4, 32'h4, 32'h4);
        cycle();
        set_cmd(1'b1, 4'd5, 32'h5, 32'h5);
        cycle();
        set_cmd(1'b1, 4'd6, 32'h6, 32'h6);
        cycle();
        set_cmd(1'b0, '0, '0, '0);
        #2;
        rst_i = 1'b1;
        model_reset();
        #1;
        chk("arst_req_valid", mst_if.req_valid, 1'b0);
        chk("arst_wb_valid", wb_valid, 1'b0);
        chk("arst_err", err_o, 1'b0);
        chk("arst_busy", busy_o, 1'b0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        set_resp(1'b1, 4'd4);
        cycle();
        set_resp(1'b0, '0);
        cycle();
        cycle();

        // Random traffic with in-order responses.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            set_cmd(1'($urandom), IdWidth'($urandom), $urandom, $urandom);
            mst_if.req_ready = 1'($urandom);
            wb_ready         = ($urandom_range(0, 3) != 0);
            if ((m_ids.size() != 0) && ($urandom_range(0, 2) != 0)) set_resp(1'b1, m_ids[0]);
            else                                                    set_resp(1'b0, '0);
            cycle();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
